// File: rtl/dma_job_scheduler.sv
// Tile-by-tile sequencer for one accelerator layer: optional weight load, then
// input read, core compute and output write per tile, each supervised by a watchdog.
module dma_job_scheduler #(
   parameter int ADDR_W    = 32,
   parameter int TILE_W    = 8,
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 reuse_wgt,
   input  logic [TILE_W-1:0]    num_tiles,
   input  logic [ADDR_W-1:0]    wgt_base,
   input  logic [ADDR_W-1:0]    in_base,
   input  logic [ADDR_W-1:0]    out_base,
   input  logic [31:0]          wgt_size,
   input  logic [31:0]          in_size,
   input  logic [31:0]          out_size,
   input  logic [ADDR_W-1:0]    in_stride,
   input  logic [ADDR_W-1:0]    out_stride,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   output logic                 read_weights_req,
   output logic                 read_input_req,
   output logic                 write_output_req,
   output logic [ADDR_W-1:0]    dma_addr,
   output logic [31:0]          dma_size,
   input  logic                 dma_weights_done,
   input  logic                 dma_input_done,
   input  logic                 dma_output_done,
   input  logic                 dma_read_error,
   input  logic                 dma_write_error,
   output logic                 core_start,
   input  logic                 core_done,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [2:0]           err_code,
   output logic [TILE_W-1:0]    tile_idx
);

   typedef enum logic [3:0] {
      S_IDLE, S_ISS_W, S_WAIT_W, S_ISS_I, S_WAIT_I, S_ISS_C,
      S_WAIT_C, S_ISS_O, S_WAIT_O, S_NEXT, S_DONE, S_ERROR
   } state_t;

   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_RD   = 3'd1;
   localparam logic [2:0] ERR_WR   = 3'd2;
   localparam logic [2:0] ERR_TO   = 3'd3;

   state_t               state_q, state_d;
   logic [TILE_W-1:0]    num_tiles_q, num_tiles_d;
   logic [ADDR_W-1:0]    wgt_base_q, wgt_base_d;
   logic [31:0]          wgt_size_q, wgt_size_d;
   logic [31:0]          in_size_q, in_size_d;
   logic [31:0]          out_size_q, out_size_d;
   logic [ADDR_W-1:0]    in_addr_q, in_addr_d;
   logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
   logic [ADDR_W-1:0]    in_stride_q, in_stride_d;
   logic [ADDR_W-1:0]    out_stride_q, out_stride_d;
   logic [TIMEOUT_W-1:0] limit_q, limit_d;
   logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic [TILE_W-1:0]    tile_idx_q, tile_idx_d;
   logic [2:0]           err_code_q, err_code_d;
   logic [ADDR_W-1:0]    dma_addr_q, dma_addr_d;
   logic [31:0]          dma_size_q, dma_size_d;

   logic [TIMEOUT_W-1:0] wd_inc;
   logic                 timeout_hit;

   assign wd_inc      = wd_cnt_q + TIMEOUT_W'(1);
   assign timeout_hit = (limit_q != '0) && (wd_inc == limit_q);

   always_comb begin
      state_d      = state_q;
      num_tiles_d  = num_tiles_q;
      wgt_base_d   = wgt_base_q;
      wgt_size_d   = wgt_size_q;
      in_size_d    = in_size_q;
      out_size_d   = out_size_q;
      in_addr_d    = in_addr_q;
      out_addr_d   = out_addr_q;
      in_stride_d  = in_stride_q;
      out_stride_d = out_stride_q;
      limit_d      = limit_q;
      wd_cnt_d     = wd_cnt_q;
      tile_idx_d   = tile_idx_q;
      err_code_d   = err_code_q;
      dma_addr_d   = dma_addr_q;
      dma_size_d   = dma_size_q;

      if (abort) begin
         state_d    = S_IDLE;
         err_code_d = ERR_NONE;
      end else begin
         case (state_q)
            S_IDLE, S_ERROR: begin
               if (start) begin
                  num_tiles_d  = num_tiles;
                  wgt_base_d   = wgt_base;
                  wgt_size_d   = wgt_size;
                  in_size_d    = in_size;
                  out_size_d   = out_size;
                  in_addr_d    = in_base;
                  out_addr_d   = out_base;
                  in_stride_d  = in_stride;
                  out_stride_d = out_stride;
                  limit_d      = timeout_limit;
                  wd_cnt_d     = '0;
                  tile_idx_d   = '0;
                  err_code_d   = ERR_NONE;
                  if (num_tiles == '0)  state_d = S_DONE;
                  else if (reuse_wgt)   state_d = S_ISS_I;
                  else                  state_d = S_ISS_W;
               end
            end
            S_ISS_W: begin
               wd_cnt_d = '0;
               state_d  = S_WAIT_W;
            end
            S_ISS_I: begin
               wd_cnt_d = '0;
               state_d  = S_WAIT_I;
            end
            S_ISS_C: begin
               wd_cnt_d = '0;
               state_d  = S_WAIT_C;
            end
            S_ISS_O: begin
               wd_cnt_d = '0;
               state_d  = S_WAIT_O;
            end
            // Within a wait: DMA error beats watchdog, watchdog beats completion.
            S_WAIT_W: begin
               wd_cnt_d = wd_inc;
               if (dma_read_error) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_RD;
               end else if (timeout_hit) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_TO;
               end else if (dma_weights_done) begin
                  state_d = S_ISS_I;
               end
            end
            S_WAIT_I: begin
               wd_cnt_d = wd_inc;
               if (dma_read_error) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_RD;
               end else if (timeout_hit) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_TO;
               end else if (dma_input_done) begin
                  state_d = S_ISS_C;
               end
            end
            S_WAIT_C: begin
               wd_cnt_d = wd_inc;
               if (timeout_hit) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_TO;
               end else if (core_done) begin
                  state_d = S_ISS_O;
               end
            end
            S_WAIT_O: begin
               wd_cnt_d = wd_inc;
               if (dma_write_error) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_WR;
               end else if (timeout_hit) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_TO;
               end else if (dma_output_done) begin
                  state_d = S_NEXT;
               end
            end
            S_NEXT: begin
               tile_idx_d = tile_idx_q + TILE_W'(1);
               in_addr_d  = in_addr_q + in_stride_q;
               out_addr_d = out_addr_q + out_stride_q;
               state_d    = (tile_idx_d < num_tiles_q) ? S_ISS_I : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      // The transfer descriptor is taken from the next-cycle values so it is
      // already valid during the one-cycle request.
      case (state_d)
         S_ISS_W: begin
            dma_addr_d = wgt_base_d;
            dma_size_d = wgt_size_d;
         end
         S_ISS_I: begin
            dma_addr_d = in_addr_d;
            dma_size_d = in_size_d;
         end
         S_ISS_O: begin
            dma_addr_d = out_addr_d;
            dma_size_d = out_size_d;
         end
         S_IDLE, S_ERROR: begin
            dma_addr_d = '0;
            dma_size_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         num_tiles_q  <= '0;
         wgt_base_q   <= '0;
         wgt_size_q   <= '0;
         in_size_q    <= '0;
         out_size_q   <= '0;
         in_addr_q    <= '0;
         out_addr_q   <= '0;
         in_stride_q  <= '0;
         out_stride_q <= '0;
         limit_q      <= '0;
         wd_cnt_q     <= '0;
         tile_idx_q   <= '0;
         err_code_q   <= ERR_NONE;
         dma_addr_q   <= '0;
         dma_size_q   <= '0;
      end else begin
         state_q      <= state_d;
         num_tiles_q  <= num_tiles_d;
         wgt_base_q   <= wgt_base_d;
         wgt_size_q   <= wgt_size_d;
         in_size_q    <= in_size_d;
         out_size_q   <= out_size_d;
         in_addr_q    <= in_addr_d;
         out_addr_q   <= out_addr_d;
         in_stride_q  <= in_stride_d;
         out_stride_q <= out_stride_d;
         limit_q      <= limit_d;
         wd_cnt_q     <= wd_cnt_d;
         tile_idx_q   <= tile_idx_d;
         err_code_q   <= err_code_d;
         dma_addr_q   <= dma_addr_d;
         dma_size_q   <= dma_size_d;
      end
   end

   assign read_weights_req = (state_q == S_ISS_W);
   assign read_input_req   = (state_q == S_ISS_I);
   assign write_output_req = (state_q == S_ISS_O);
   assign core_start       = (state_q == S_ISS_C);
   assign busy             = (state_q != S_IDLE) && (state_q != S_ERROR);
   assign done             = (state_q == S_DONE);
   assign error            = (state_q == S_ERROR);
   assign err_code         = err_code_q;
   assign tile_idx         = tile_idx_q;
   assign dma_addr         = dma_addr_q;
   assign dma_size         = dma_size_q;

endmodule
